// File: rtl/seq_bcd_to_bin_pkg.sv
// Shared constants and state encoding for the sequential BCD-to-binary converter.
// Digit geometry, reverse double-dabble correction constants and the FSM enum live here.
package seq_bcd_to_bin_pkg;

    localparam int          DIGIT_W     = 4;
    localparam logic [3:0]  CORR_THRESH = 4'd8;
    localparam logic [3:0]  CORR_SUB    = 4'd3;
    localparam logic [3:0]  DIGIT_MAX   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return d > DIGIT_MAX;
    endfunction

endpackage

// File: rtl/seq_bcd_to_bin_if.sv
// Start/done handshake bundle between the digit-entry controller (master)
// and the converter (slave), carrying the BCD operand and the converted result.
interface seq_bcd_to_bin_if #(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 17
);

    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic                  negative;
    logic                  busy;
    logic                  done;
    logic                  valid;
    logic                  error;
    logic [BIN_W-1:0]      magnitude;
    logic [BIN_W:0]        value;

    modport master (
        output start, bcd, negative,
        input  busy, done, valid, error, magnitude, value
    );

    modport slave (
        input  start, bcd, negative,
        output busy, done, valid, error, magnitude, value
    );

endinterface

// File: rtl/seq_bcd_to_bin_bcd_digit_corrector.sv
// One BCD digit of the reverse double-dabble step: after the right shift,
// a digit that landed at 8 or above has 3 subtracted.
module bcd_digit_corrector
    import seq_bcd_to_bin_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= CORR_THRESH) ? (i_digit - CORR_SUB) : i_digit;

endmodule

// File: rtl/seq_bcd_to_bin.sv
// Sequential reverse double-dabble: signed packed-BCD entry in, binary magnitude
// and two's-complement value out, using a start/busy/done/valid handshake.
module seq_bcd_to_bin
    import seq_bcd_to_bin_pkg::*;
#(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 17
) (
    input  logic               clk,
    input  logic               rst,
    seq_bcd_to_bin_if.slave    bus
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

    state_t                r_state;
    logic [BCD_W-1:0]      r_bcd;
    logic [BIN_W-1:0]      r_bin;
    logic                  r_neg;
    logic                  r_err;
    logic [CNT_W-1:0]      r_cnt;

    logic                  r_busy;
    logic                  r_done;
    logic                  r_valid;
    logic                  r_error;
    logic [BIN_W-1:0]      r_mag;
    logic [BIN_W:0]        r_value;

    logic [BCD_W+BIN_W-1:0] w_shift;
    logic [BCD_W-1:0]       w_shift_bcd;
    logic [BIN_W-1:0]       w_shift_bin;
    logic [BCD_W-1:0]       w_corr_bcd;
    logic [DIGITS-1:0]      w_bad;
    logic                   w_any_bad;
    logic [BIN_W:0]         w_bin_ext;
    logic [BIN_W:0]         w_bin_neg;

    // The whole working register moves right as one word; bits leaving the
    // lowest BCD digit enter the top of the binary accumulator.
    assign w_shift     = {r_bcd, r_bin} >> 1;
    assign w_shift_bcd = w_shift[BCD_W+BIN_W-1 -: BCD_W];
    assign w_shift_bin = w_shift[BIN_W-1:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_corrector u_corr (
                .i_digit (w_shift_bcd[gi*DIGIT_W +: DIGIT_W]),
                .o_digit (w_corr_bcd[gi*DIGIT_W +: DIGIT_W])
            );
            assign w_bad[gi] = digit_invalid(r_bcd[gi*DIGIT_W +: DIGIT_W]);
        end
    endgenerate

    assign w_any_bad = |w_bad;
    assign w_bin_ext = {1'b0, r_bin};
    assign w_bin_neg = -w_bin_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_mag   <= '0;
            r_value <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_bcd   <= bus.bcd;
                        r_bin   <= '0;
                        r_neg   <= bus.negative;
                        r_valid <= 1'b0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_cnt <= '0;
                    if (w_any_bad) begin
                        r_err   <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_err   <= 1'b0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= w_corr_bcd;
                    r_bin <= w_shift_bin;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_SHIFT) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    // Negative zero needs no special case: -0 is 0 in two's complement.
                    if (r_err) begin
                        r_mag   <= '0;
                        r_value <= '0;
                        r_error <= 1'b1;
                    end else begin
                        r_mag   <= r_bin;
                        r_value <= r_neg ? w_bin_neg : w_bin_ext;
                        r_error <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.valid     = r_valid;
    assign bus.error     = r_error;
    assign bus.magnitude = r_mag;
    assign bus.value     = r_value;

endmodule

// File: tb/tb_seq_bcd_to_bin.sv
// Scoreboard bench for seq_bcd_to_bin: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_bcd_to_bin;

    localparam int DIGITS = 5;
    localparam int BIN_W  = 17;

    typedef struct {
        logic [BIN_W-1:0] mag;
        logic [BIN_W:0]   val;
        logic             err;
        int               done_cyc;
        string            name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    seq_bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    seq_bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 mag=%h expected no done (cycle %0d)",
                         bus.magnitude, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("txn %s: mag=%h val=%h err=%b cyc=%0d", e.name, bus.magnitude,
                         bus.value, bus.error, cyc);
                chk({e.name, "_mag"},   64'(bus.magnitude), 64'(e.mag));
                chk({e.name, "_val"},   64'(bus.value),     64'(e.val));
                chk({e.name, "_err"},   64'(bus.error),     64'(e.err));
                chk({e.name, "_cyc"},   64'(cyc),           64'(e.done_cyc));
                chk({e.name, "_busy"},  64'(bus.busy),      64'd0);
                chk({e.name, "_valid"}, 64'(bus.valid),     64'd1);
            end
        end
    end

    task automatic push_exp(input string nm, input logic [BIN_W-1:0] m, input logic [BIN_W:0] v,
                            input logic e, input int dc);
        exp_t x;
        x.mag = m; x.val = v; x.err = e; x.done_cyc = dc; x.name = nm;
        sb_q.push_back(x);
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", nm, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run_conv(input string nm, input logic [19:0] b, input logic n,
                            input logic [BIN_W-1:0] em, input logic [BIN_W:0] ev,
                            input logic ee, input int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.bcd = b; bus.negative = n;
        @(posedge clk); #1;
        push_exp(nm, em, ev, ee, cyc + lat);
        chk({nm, "_busy_acc"},  64'(bus.busy),  64'd1);
        chk({nm, "_valid_acc"}, 64'(bus.valid), 64'd0);
        // Scramble inputs: the conversion in flight must not see them.
        bus.start = 1'b0; bus.bcd = 20'hFFFFF; bus.negative = ~n;
        wait_drain(nm);
        repeat (3) @(negedge clk);
        chk({nm, "_valid_hold"}, 64'(bus.valid),     64'd1);
        chk({nm, "_mag_hold"},   64'(bus.magnitude), 64'(em));
        chk({nm, "_val_hold"},   64'(bus.value),     64'(ev));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        bus.start = 1'b0; bus.bcd = '0; bus.negative = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(bus.busy),      64'd0);
        chk("rst_done",  64'(bus.done),      64'd0);
        chk("rst_valid", 64'(bus.valid),     64'd0);
        chk("rst_error", 64'(bus.error),     64'd0);
        chk("rst_mag",   64'(bus.magnitude), 64'd0);
        chk("rst_val",   64'(bus.value),     64'd0);
        rst = 1'b0;

        run_conv("d123",    20'h00123, 1'b0, 17'h0007B, 18'h0007B, 1'b0, 19);
        run_conv("d99999",  20'h99999, 1'b0, 17'h1869F, 18'h1869F, 1'b0, 19);
        run_conv("dneg42",  20'h00042, 1'b1, 17'd42,    18'h3FFD6, 1'b0, 19);
        run_conv("dnegz",   20'h00000, 1'b1, 17'd0,     18'h00000, 1'b0, 19);
        run_conv("d65535n", 20'h65535, 1'b1, 17'h0FFFF, 18'h30001, 1'b0, 19);
        run_conv("d90000",  20'h90000, 1'b0, 17'h15F90, 18'h15F90, 1'b0, 19);
        run_conv("badA5",   20'h000A5, 1'b0, 17'd0,     18'd0,     1'b1, 2);
        run_conv("badF0",   20'hF0000, 1'b1, 17'd0,     18'd0,     1'b1, 2);

        // Start re-pulsed mid-conversion must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.bcd = 20'h00123; bus.negative = 1'b0;
        @(posedge clk); #1;
        a = cyc;
        push_exp("ign123", 17'h0007B, 18'h0007B, 1'b0, a + 19);
        bus.start = 1'b0;
        while (cyc < a + 5) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.bcd = 20'h00999;
        @(posedge clk); #1; bus.start = 1'b0;
        while (cyc < a + 10) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.bcd = 20'h00777;
        @(posedge clk); #1; bus.start = 1'b0;
        wait_drain("ign123");
        repeat (25) @(negedge clk);

        // Back-to-back: start held high across FINISH -> IDLE.
        @(negedge clk);
        bus.start = 1'b1; bus.bcd = 20'h00042; bus.negative = 1'b0;
        @(posedge clk); #1;
        a = cyc;
        push_exp("b2b_42", 17'h0002A, 18'h0002A, 1'b0, a + 19);
        bus.bcd = 20'h00500; bus.negative = 1'b1;
        while (cyc < a + 20) begin @(posedge clk); #1; end
        push_exp("b2b_n500", 17'h001F4, 18'h3FE0C, 1'b0, a + 39);
        bus.start = 1'b0;
        wait_drain("b2b");

        // Reset mid-SHIFT: everything clears at once, no done follows.
        @(negedge clk);
        bus.start = 1'b1; bus.bcd = 20'h00123; bus.negative = 1'b0;
        @(posedge clk); #1;
        a = cyc;
        bus.start = 1'b0;
        while (cyc < a + 8) begin @(posedge clk); #1; end
        #1 rst = 1'b1;
        #1;
        chk("mrst_busy",  64'(bus.busy),      64'd0);
        chk("mrst_done",  64'(bus.done),      64'd0);
        chk("mrst_valid", 64'(bus.valid),     64'd0);
        chk("mrst_mag",   64'(bus.magnitude), 64'd0);
        chk("mrst_val",   64'(bus.value),     64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        run_conv("d7_after_rst", 20'h00007, 1'b0, 17'd7, 18'd7, 1'b0, 19);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_bcd_to_bin.md
# seq_bcd_to_bin

Sequential reverse double-dabble converter: takes a signed decimal value entered as packed BCD digits plus a sign flag, and produces the binary magnitude and its two's-complement signed form. It is the decimal-entry counterpart of the binary-to-BCD display path. It feeds operands entered digit-by-digit from switches or buttons into the arithmetic units (e.g. the sequential multiplier) using the same start/done handshake. The digit-entry controller drives it and the arithmetic path consumes it.

## Interface
Parameters:
- DIGITS, 5, number of BCD digits accepted.
- BIN_W, 17, magnitude width; must satisfy 10^DIGITS − 1 < 2^BIN_W.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; one clock, no other reset source.
- start  in  1  conversion request, sampled only in IDLE.
- bcd  in  4*DIGITS  packed BCD; digit 0 in bits [3:0].
- negative  in  1  sign of the entered value.
- busy  out  1  high from the cycle after an accepted start through FINISH.
- done  out  1  one-cycle pulse when outputs are updated.
- valid  out  1  level; high from done until next accepted start or reset.
- error  out  1  set with done if any digit > 9; held with valid.
- magnitude  out  BIN_W  unsigned binary value.
- value  out  BIN_W+1  two's-complement signed value.

## Operation
- FSM states: IDLE, CHECK, SHIFT, FINISH.
- IDLE:
  - start=1 → latch bcd and negative into the working register {bcd_reg, bin_reg=0}.
  - Clear valid and error, go to CHECK.
- CHECK:
  - Any digit > 9 → go to FINISH with error flagged; the shift phase is skipped.
  - Otherwise clear the shift counter and go to SHIFT.
- SHIFT, per cycle:
  - Logical right shift of the {bcd_reg, bin_reg} concatenation by 1.
  - Then each 4-bit digit of bcd_reg that is ≥ 8 has 3 subtracted.
  - Counter increments; after exactly BIN_W shift cycles, go to FINISH.
- FINISH:
  - magnitude ← bin_reg.
  - value ← negative ? −{0,bin_reg} : {0,bin_reg}.
  - Pulse done, set valid, return to IDLE.
  - On error: magnitude=0, value=0, error=1.
- Negative zero: bcd=0 with negative=1 yields value=0 (no distinct encoding).
- start while busy (CHECK/SHIFT/FINISH) is ignored, not queued.
- start held high across FINISH→IDLE starts a new conversion in the IDLE cycle (back-to-back allowed).
- Inputs are sampled only at acceptance; later changes do not affect the conversion in flight.

## Timing
- Reset values: busy=0, done=0, valid=0, error=0, magnitude=0, value=0, state=IDLE.
- Reset mid-conversion discards all state immediately; no done is produced.
- Start accepted at edge 0 → busy=1 after edge 0.
- Valid input: CHECK for 1 cycle, SHIFT for BIN_W cycles, done=1 during cycle BIN_W+2 (cycle 19 with defaults).
- Invalid digit: done=1 with error=1 during cycle 2.
- busy falls together with the done pulse, i.e. deasserts in the same cycle done is high.
- magnitude, value and error are stable while valid=1.

## Structure
- Shared package:
  - BCD digit width (4).
  - Correction threshold (8) and correction constant (3).
  - FSM state encoding enum.
- One sub-module, bcd_digit_corrector: combinational, 4-bit in → 4-bit out, subtracts 3 when the input is ≥ 8; instantiated DIGITS times.
- All other logic (FSM, counter of width clog2(BIN_W+1), working register, output registers) lives in the top.

## Test plan
- bcd=20'h00123, negative=0, start pulse → done at cycle 19, magnitude=17'h0007B, value=18'h0007B, error=0.
- bcd=20'h99999, negative=0 → magnitude=17'h1869F, value=18'h1869F.
- bcd=20'h00042, negative=1 → magnitude=42, value=18'h3FFD6; bcd=0, negative=1 → value=0.
- bcd=20'h000A5 → done and error=1 at cycle 2, magnitude=0, value=0, busy never in SHIFT.
- start re-pulsed at cycles 5 and 10 of a conversion of 20'h00123 → ignored; single done at cycle 19 with 123.
- rst asserted at cycle 8 mid-SHIFT → all outputs 0 within same cycle, no done; a new start then converts 20'h00007 → magnitude 7.
